// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the fetch port, the data port and the single-port RAM port that
//   meet at mem_arbiter.
//
//   Fetch : if_req, if_addr      -> arbiter ; if_inst, if_ready  <- arbiter
//   Data  : mem_rd, mem_wr,
//           mem_addr, mem_wdata  -> arbiter ; mem_rdata, mem_ready <- arbiter
//   Ctrl  : stall_req            <- arbiter (to pipeline control)
//   RAM   : ram_addr, ram_wdata,
//           ram_en, ram_oe, ram_we <- arbiter ; ram_rdata -> arbiter
//
//   slave  : the arbiter's view
//   master : the surrounding system's view (pipeline + RAM device)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_inst;
   logic              if_ready;

   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   logic              stall_req;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_en;
   logic              ram_oe;
   logic              ram_we;

   modport slave (
      input  if_req, if_addr,
      output if_inst, if_ready,
      input  mem_rd, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      output stall_req,
      output ram_addr, ram_wdata, ram_en, ram_oe, ram_we,
      input  ram_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_inst, if_ready,
      output mem_rd, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      input  stall_req,
      input  ram_addr, ram_wdata, ram_en, ram_oe, ram_we,
      output ram_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port RAM between instruction fetch and the MEM stage.
//   Data requests beat fetch unless fetch has been passed over STARVE_LIM
//   consecutive times. Reads take one RAM cycle; writes run a setup cycle,
//   WR_CYCLES strobe cycles and a hold cycle. Every access ends in a DONE
//   cycle that pulses the owner's ready and presents the read word.
//
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (fetch, data, stall_req and RAM signals)
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int WR_CYCLES  = 2,
   parameter int STARVE_LIM = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam int STARVE_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);
   localparam logic [2:0]          WR_LAST    = 3'(WR_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                owner_mem;   // 1: data port owns the access, 0: fetch
   logic [2:0]          wr_cnt;
   logic [STARVE_W-1:0] starve;
   logic [DATA_W-1:0]   if_inst_q;
   logic [DATA_W-1:0]   mem_rdata_q;

   logic data_req;
   logic fetch_force;
   logic grant_mem;
   logic grant_if;

   // Arbitration decision, only acted on in IDLE.
   always_comb begin
      data_req    = bus.mem_rd | bus.mem_wr;
      fetch_force = bus.if_req && (starve == STARVE_MAX);
      grant_mem   = data_req && !fetch_force;
      grant_if    = bus.if_req && !grant_mem;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            // Simultaneous rd and wr is treated as a write.
            if (grant_mem)     state_nxt = bus.mem_wr ? WR_SETUP : RD;
            else if (grant_if) state_nxt = RD;
         end
         RD:       state_nxt = DONE;
         WR_SETUP: state_nxt = WR_PULSE;
         WR_PULSE: state_nxt = (wr_cnt == 3'd0) ? WR_HOLD : WR_PULSE;
         WR_HOLD:  state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         owner_mem   <= 1'b0;
         wr_cnt      <= '0;
         starve      <= '0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
      end else begin
         state <= state_nxt;

         if (state == IDLE) begin
            if (grant_mem) begin
               addr_q    <= bus.mem_addr;
               wdata_q   <= bus.mem_wdata;
               owner_mem <= 1'b1;
               if (!bus.if_req)              starve <= '0;
               else if (starve < STARVE_MAX) starve <= starve + STARVE_W'(1);
            end else if (grant_if) begin
               addr_q    <= bus.if_addr;
               owner_mem <= 1'b0;
               starve    <= '0;
            end else if (!bus.if_req) begin
               starve <= '0;
            end
         end

         // Counter is loaded in setup so it already holds WR_CYCLES-1 on the
         // first strobe cycle; the strobe ends after the cycle it reads 0.
         if (state == WR_SETUP)      wr_cnt <= WR_LAST;
         else if (state == WR_PULSE) wr_cnt <= wr_cnt - 3'd1;

         if (state == RD) begin
            if (owner_mem) mem_rdata_q <= bus.ram_rdata;
            else           if_inst_q   <= bus.ram_rdata;
         end
      end
   end

   // RAM controls and ready pulses decode the registered state directly.
   always_comb begin
      bus.ram_addr  = addr_q;
      bus.ram_wdata = wdata_q;
      bus.ram_en    = (state == RD) || (state == WR_SETUP) ||
                      (state == WR_PULSE) || (state == WR_HOLD);
      bus.ram_oe    = (state == RD);
      bus.ram_we    = (state == WR_PULSE);
      bus.if_ready  = (state == DONE) && !owner_mem;
      bus.mem_ready = (state == DONE) && owner_mem;
      bus.if_inst   = if_inst_q;
      bus.mem_rdata = mem_rdata_q;
      bus.stall_req = (bus.if_req & ~bus.if_ready) |
                      ((bus.mem_rd | bus.mem_wr) & ~bus.mem_ready);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Bench for mem_arbiter with a behavioural single-port RAM. Each task runs
//   one scenario and checks cycle-level timing inline; completed transfers
//   are checked against a scoreboard filled when the request is issued.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int WR  = 2;
   localparam int LIM = 4;

   typedef struct {
      bit          wr;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   exp_t        exp_mem[$];
   logic [15:0] exp_if[$];
   logic [15:0] ram_arr [65536];

   mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_arbiter #(
      .ADDR_W(16),
      .DATA_W(16),
      .WR_CYCLES(WR),
      .STARVE_LIM(LIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // RAM device: combinational read while ram_oe, write on the clock edge.
   assign bus.ram_rdata = bus.ram_oe ? ram_arr[bus.ram_addr] : 16'h0000;

   always @(posedge clk)
      if (bus.ram_en && bus.ram_we) ram_arr[bus.ram_addr] <= bus.ram_wdata;

   // Scoreboard: every ready pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.if_ready) begin
            checks++;
            if (exp_if.size() == 0) begin
               errors++;
               $display("FAIL sb_if_unexpected: if_ready=1 with nothing pending");
            end else begin
               logic [15:0] e;
               e = exp_if.pop_front();
               if (bus.if_inst !== e) begin
                  errors++;
                  $display("FAIL sb_if_inst: got %h expected %h", bus.if_inst, e);
               end
            end
         end
         if (bus.mem_ready) begin
            checks++;
            if (exp_mem.size() == 0) begin
               errors++;
               $display("FAIL sb_mem_unexpected: mem_ready=1 with nothing pending");
            end else begin
               exp_t e;
               e = exp_mem.pop_front();
               if (!e.wr && bus.mem_rdata !== e.data) begin
                  errors++;
                  $display("FAIL sb_mem_rdata: got %h expected %h", bus.mem_rdata, e.data);
               end
            end
         end
      end
   end

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      ram_arr[a] <= d;
   endtask

   task automatic do_mem_read(input logic [15:0] a, input logic [15:0] d);
      int lat;
      exp_mem.push_back('{1'b0, d});
      @(posedge clk); #1;
      bus.mem_rd   = 1'b1;
      bus.mem_addr = a;
      lat = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.mem_ready) begin lat = c; break; end
      end
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL rd_latency @%h: got %0d expected 2", a, lat);
      end
      @(posedge clk); #1;
      bus.mem_rd = 1'b0;
   endtask

   task automatic do_mem_write(input logic [15:0] a, input logic [15:0] d);
      int lat;
      exp_mem.push_back('{1'b1, d});
      @(posedge clk); #1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = a;
      bus.mem_wdata = d;
      lat = -1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.mem_ready) begin lat = c; break; end
      end
      checks++;
      if (lat != 3 + WR) begin
         errors++;
         $display("FAIL wr_latency @%h: got %0d expected %0d", a, lat, 3 + WR);
      end
      @(posedge clk); #1;
      bus.mem_wr = 1'b0;
   endtask

   task automatic test_reset();
      logic [54:0] outs;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      outs = {bus.if_inst, bus.mem_rdata, bus.if_ready, bus.mem_ready,
              bus.ram_addr, bus.ram_en, bus.ram_oe, bus.ram_we, bus.stall_req};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.ram_en, bus.stall_req, bus.ram_wdata} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: en=%b stall=%b wdata=%h expected 0",
                  bus.ram_en, bus.stall_req, bus.ram_wdata);
      end
   endtask

   task automatic test_fetch();
      preload(16'h0003, 16'h3360);
      exp_if.push_back(16'h3360);
      @(posedge clk); #1;
      bus.if_req  = 1'b1;
      bus.if_addr = 16'h0003;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         case (c)
            0: if (!(bus.stall_req === 1'b1 && bus.ram_en === 1'b0)) begin
                  errors++;
                  $display("FAIL fetch_c0: stall=%b en=%b expected 1/0", bus.stall_req, bus.ram_en);
               end
            1: if ({bus.ram_en, bus.ram_oe, bus.ram_we} !== 3'b110 || bus.ram_addr !== 16'h0003) begin
                  errors++;
                  $display("FAIL fetch_c1: en/oe/we=%b addr=%h expected 110/0003",
                           {bus.ram_en, bus.ram_oe, bus.ram_we}, bus.ram_addr);
               end
            2: if (bus.if_ready !== 1'b1) begin
                  errors++;
                  $display("FAIL fetch_c2_ready: got %b expected 1", bus.if_ready);
               end
            default: if (bus.stall_req !== 1'b0 || bus.if_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL fetch_c3: stall=%b ready=%b expected 0/0", bus.stall_req, bus.if_ready);
               end
         endcase
         @(posedge clk); #1;
         if (c == 2) bus.if_req = 1'b0;
      end
   endtask

   task automatic test_write_timing();
      exp_mem.push_back('{1'b1, 16'h0001});
      @(posedge clk); #1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = 16'h8000;
      bus.mem_wdata = 16'h0001;
      for (int c = 0; c < 7; c++) begin
         logic ew, er;
         @(negedge clk);
         ew = (c >= 2 && c <= 1 + WR);
         er = (c == 3 + WR);
         checks++;
         if ({bus.ram_we, bus.mem_ready} !== {ew, er}) begin
            errors++;
            $display("FAIL wr_c%0d_we_ready: got %b%b expected %b%b", c,
                     bus.ram_we, bus.mem_ready, ew, er);
         end
         if (c >= 1 && c <= 2 + WR) begin
            checks++;
            if (bus.ram_addr !== 16'h8000 || bus.ram_wdata !== 16'h0001 || bus.ram_en !== 1'b1) begin
               errors++;
               $display("FAIL wr_c%0d_bus: addr=%h wdata=%h en=%b expected 8000/0001/1", c,
                        bus.ram_addr, bus.ram_wdata, bus.ram_en);
            end
         end
         @(posedge clk); #1;
         if (c == 3 + WR) bus.mem_wr = 1'b0;
      end
      do_mem_read(16'h8000, 16'h0001);
   endtask

   task automatic test_priority();
      preload(16'h0040, 16'hAAAA);
      preload(16'h0050, 16'h5555);
      exp_mem.push_back('{1'b0, 16'hAAAA});
      exp_if.push_back(16'h5555);
      @(posedge clk); #1;
      bus.mem_rd   = 1'b1;
      bus.mem_addr = 16'h0040;
      bus.if_req   = 1'b1;
      bus.if_addr  = 16'h0050;
      for (int c = 0; c < 7; c++) begin
         logic [2:0] e;
         @(negedge clk);
         e = {1'(c <= 4), 1'(c == 2), 1'(c == 5)};
         checks++;
         if ({bus.stall_req, bus.mem_ready, bus.if_ready} !== e) begin
            errors++;
            $display("FAIL prio_c%0d stall/mrdy/irdy: got %b expected %b", c,
                     {bus.stall_req, bus.mem_ready, bus.if_ready}, e);
         end
         if (c == 4) begin
            checks++;
            if (bus.ram_oe !== 1'b1 || bus.ram_addr !== 16'h0050) begin
               errors++;
               $display("FAIL prio_fetch_grant: oe=%b addr=%h expected 1/0050", bus.ram_oe, bus.ram_addr);
            end
         end
         @(posedge clk); #1;
         if (c == 2) bus.mem_rd = 1'b0;
         if (c == 5) bus.if_req = 1'b0;
      end
   endtask

   task automatic test_starvation();
      bit log[$];
      int n_mem = 0, n_if = 0;
      preload(16'h0100, 16'h1111);
      preload(16'h0200, 16'h2222);
      for (int i = 0; i < 2 * LIM; i++) exp_mem.push_back('{1'b0, 16'h2222});
      exp_if.push_back(16'h1111);
      exp_if.push_back(16'h1111);
      @(posedge clk); #1;
      bus.if_req   = 1'b1;
      bus.if_addr  = 16'h0100;
      bus.mem_rd   = 1'b1;
      bus.mem_addr = 16'h0200;
      for (int c = 0; c < 200 && (bus.if_req || bus.mem_rd); c++) begin
         @(negedge clk);
         if (bus.ram_oe) log.push_back(bus.ram_addr == 16'h0100);
         if (bus.mem_ready) n_mem++;
         if (bus.if_ready)  n_if++;
         @(posedge clk); #1;
         if (n_mem == 2 * LIM) bus.mem_rd = 1'b0;
         if (n_if == 2)        bus.if_req = 1'b0;
      end
      checks++;
      if (log.size() != 2 * LIM + 2) begin
         errors++;
         $display("FAIL starve_grant_count: got %0d expected %0d", log.size(), 2 * LIM + 2);
      end
      for (int i = 0; i < log.size() && i < 2 * LIM + 2; i++) begin
         bit e;
         e = (i == LIM) || (i == 2 * LIM + 1);
         checks++;
         if (log[i] !== e) begin
            errors++;
            $display("FAIL starve_grant_%0d is_fetch: got %b expected %b", i, log[i], e);
         end
      end
   endtask

   task automatic test_reset_abort();
      preload(16'h1234, 16'h0000);
      exp_mem.push_back('{1'b1, 16'hBEEF});
      @(posedge clk); #1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = 16'h1234;
      bus.mem_wdata = 16'hBEEF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if (bus.ram_we !== 1'b1) begin
               errors++;
               $display("FAIL abort_pulse_seen: ram_we=%b expected 1", bus.ram_we);
            end
         end
         if (c == 4) begin
            checks++;
            if ({bus.ram_we, bus.ram_en, bus.mem_ready} !== 3'b000) begin
               errors++;
               $display("FAIL abort_after_rst we/en/rdy: got %b expected 000",
                        {bus.ram_we, bus.ram_en, bus.mem_ready});
            end
            exp_mem.delete();
         end
         @(posedge clk); #1;
         if (c == 2) begin rst = 1'b1; bus.mem_wr = 1'b0; end
         if (c == 3) rst = 1'b0;
      end
      // A stray mem_ready during these idle cycles would hit the scoreboard.
      repeat (6) @(posedge clk);
      do_mem_write(16'h1234, 16'hCAFE);
      do_mem_read(16'h1234, 16'hCAFE);
   endtask

   task automatic test_rw_collision();
      int n_we = 0, n_oe = 0, rdy = -1;
      exp_mem.push_back('{1'b1, 16'h7E57});
      @(posedge clk); #1;
      bus.mem_rd    = 1'b1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = 16'hFFFF;
      bus.mem_wdata = 16'h7E57;
      for (int c = 0; c < 12 && rdy < 0; c++) begin
         @(negedge clk);
         if (bus.ram_we) begin
            n_we++;
            checks++;
            if (bus.ram_addr !== 16'hFFFF) begin
               errors++;
               $display("FAIL coll_addr: got %h expected ffff", bus.ram_addr);
            end
         end
         if (bus.ram_oe) n_oe++;
         if (bus.mem_ready) rdy = c;
      end
      @(posedge clk); #1;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      checks++;
      if (n_we != WR || n_oe != 0 || rdy != 3 + WR) begin
         errors++;
         $display("FAIL coll_write: we_cycles=%0d oe_cycles=%0d ready_at=%0d expected %0d/0/%0d",
                  n_we, n_oe, rdy, WR, 3 + WR);
      end
      do_mem_read(16'hFFFF, 16'h7E57);
   endtask

   initial begin
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      test_reset();
      test_fetch();
      test_write_timing();
      test_priority();
      test_starvation();
      test_reset_abort();
      test_rw_collision();
      repeat (3) @(posedge clk);
      checks++;
      if (exp_mem.size() != 0 || exp_if.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: mem=%0d if=%0d expected 0/0", exp_mem.size(), exp_if.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
